// File: rtl/issue_select_pkg.sv
// Shared types and sizing for the issue-select stage: RS/issue packet layouts,
// functional-unit classes and per-class issue budgets.
package issue_select_pkg;

  localparam int RS_SZ    = 16;  // must be a power of two (scan index wraps naturally)
  localparam int N        = 2;
  localparam int NUM_ALU  = 2;
  localparam int NUM_MULT = 1;
  localparam int NUM_BR   = 1;
  localparam int NUM_LDST = 1;
  localparam int MULT_LAT = 4;   // must be > 1: MULT claims must not share offset 1 with ALU/BR

  localparam int B_MASK_W = 4;
  localparam int TAG_W    = 6;
  localparam int OP_W     = 8;
  localparam int IDX_W    = $clog2(RS_SZ);
  localparam int CLM_W    = $clog2(N + 1);

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_BR   = 2'd2,
    FU_LDST = 2'd3
  } fu_type_e;

  typedef struct packed {
    fu_type_e              fu_type;
    logic [B_MASK_W-1:0]   b_mask;
    logic [TAG_W-1:0]      dest_tag;
    logic [TAG_W-1:0]      src1_tag;
    logic [TAG_W-1:0]      src2_tag;
    logic [OP_W-1:0]       op;
    logic                  src1_ready;
    logic                  src2_ready;
  } rs_packet_t;

  typedef struct packed {
    fu_type_e              fu_type;
    logic [B_MASK_W-1:0]   b_mask;
    logic [TAG_W-1:0]      dest_tag;
    logic [TAG_W-1:0]      src1_tag;
    logic [TAG_W-1:0]      src2_tag;
    logic [OP_W-1:0]       op;
  } iss_packet_t;

  // Drops the ready bits and clears branch bits resolved this cycle.
  function automatic iss_packet_t to_issue(rs_packet_t p, logic [B_MASK_W-1:0] resolve);
    iss_packet_t q;
    q.fu_type  = p.fu_type;
    q.b_mask   = p.b_mask & ~resolve;
    q.dest_tag = p.dest_tag;
    q.src1_tag = p.src1_tag;
    q.src2_tag = p.src2_tag;
    q.op       = p.op;
    return q;
  endfunction

endpackage

// File: rtl/issue_select_if.sv
// RS <-> issue-select bundle. The RS (master) presents entries; issue-select
// (slave) returns the same-cycle pick vector and the registered issue slots.
interface issue_select_if;
  import issue_select_pkg::*;

  // rs_data_issuing is a same-cycle acceptance: every set bit means that entry
  // was taken and the RS must retire it on the coming edge (no retry).
  rs_packet_t  [RS_SZ-1:0] rs_data;
  logic        [RS_SZ-1:0] rs_valid;
  logic                    lsq_ready;
  logic     [B_MASK_W-1:0] b_mm_resolve;
  logic                    b_mm_mispred;
  logic        [RS_SZ-1:0] rs_data_issuing;
  iss_packet_t     [N-1:0] iss_packets;
  logic            [N-1:0] iss_valid;

  modport master (
    output rs_data, rs_valid, lsq_ready, b_mm_resolve, b_mm_mispred,
    input  rs_data_issuing, iss_packets, iss_valid
  );

  modport slave (
    input  rs_data, rs_valid, lsq_ready, b_mm_resolve, b_mm_mispred,
    output rs_data_issuing, iss_packets, iss_valid
  );

endinterface

// File: rtl/issue_select_rr_class_picker.sv
// Combinational rotating scan: starting at rr_ptr, take the first ready entries
// that fit the width, class, LSQ and CDB writeback budgets.
module rr_class_picker
  import issue_select_pkg::*;
(
  input  logic     [RS_SZ-1:0]            ready,
  input  fu_type_e [RS_SZ-1:0]            fu_type,
  input  logic     [IDX_W-1:0]            rr_ptr,
  input  logic                            lsq_ready,
  input  logic     [CLM_W-1:0]            claims_at_1,
  input  logic     [CLM_W-1:0]            claims_at_lat,
  output logic     [RS_SZ-1:0]            pick,
  output logic     [N-1:0][IDX_W-1:0]     pick_idx,
  output logic     [N-1:0]                pick_vld,
  output logic     [IDX_W-1:0]            last_idx,
  output logic     [CLM_W-1:0]            new_at_lat
);

  logic [IDX_W-1:0] idx;
  logic             ok;
  int               n_pick, n_alu, n_mult, n_br, n_ldst, n_wb1, n_wbl;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_vld = '0;
    last_idx = rr_ptr;
    idx      = '0;
    ok       = 1'b0;
    n_pick   = 0;
    n_alu    = 0;
    n_mult   = 0;
    n_br     = 0;
    n_ldst   = 0;
    n_wb1    = 0;
    n_wbl    = 0;
    for (int k = 0; k < RS_SZ; k++) begin
      idx = rr_ptr + k[IDX_W-1:0];
      ok  = ready[idx] && (n_pick < N);
      // ALU/BR write the CDB one cycle after issue; MULT after MULT_LAT; LDST goes via the LSQ.
      case (fu_type[idx])
        FU_ALU:  ok = ok && (n_alu  < NUM_ALU)  && (int'(claims_at_1)   + n_wb1 < N);
        FU_BR:   ok = ok && (n_br   < NUM_BR)   && (int'(claims_at_1)   + n_wb1 < N);
        FU_MULT: ok = ok && (n_mult < NUM_MULT) && (int'(claims_at_lat) + n_wbl < N);
        FU_LDST: ok = ok && (n_ldst < NUM_LDST) && lsq_ready;
        default: ok = 1'b0;
      endcase
      if (ok) begin
        pick[idx] = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (j == n_pick) begin
            pick_idx[j] = idx;
            pick_vld[j] = 1'b1;
          end
        end
        last_idx = idx;
        n_pick   = n_pick + 1;
        case (fu_type[idx])
          FU_ALU:  begin n_alu  = n_alu  + 1; n_wb1 = n_wb1 + 1; end
          FU_BR:   begin n_br   = n_br   + 1; n_wb1 = n_wb1 + 1; end
          FU_MULT: begin n_mult = n_mult + 1; n_wbl = n_wbl + 1; end
          default: n_ldst = n_ldst + 1;
        endcase
      end
    end
    new_at_lat = CLM_W'(n_wbl);
  end

endmodule

// File: rtl/issue_select.sv
// Issue stage: picks up to N ready RS entries per cycle and registers them into
// the issue slots, tracking future CDB writeback usage and a round-robin start.
module issue_select
  import issue_select_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  issue_select_if.slave io
);

  logic     [RS_SZ-1:0]          ready;
  fu_type_e [RS_SZ-1:0]          fu_vec;
  logic     [RS_SZ-1:0]          pick;
  logic     [N-1:0][IDX_W-1:0]   pick_idx;
  logic     [N-1:0]              pick_vld;
  logic     [IDX_W-1:0]          last_idx;
  logic     [CLM_W-1:0]          new_at_lat;

  logic     [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic     [MULT_LAT:1][CLM_W-1:0] wb_claims_q, wb_claims_d;
  iss_packet_t [N-1:0]           iss_packets_q, iss_packets_d;
  logic     [N-1:0]              iss_valid_q, iss_valid_d;

  always_comb begin
    ready  = '0;
    fu_vec = fu_vec_default();
    for (int i = 0; i < RS_SZ; i++) begin
      fu_vec[i] = io.rs_data[i].fu_type;
      ready[i]  = ~reset & io.rs_valid[i] & io.rs_data[i].src1_ready & io.rs_data[i].src2_ready &
                  ~(io.b_mm_mispred & |(io.rs_data[i].b_mask & io.b_mm_resolve));
    end
  end

  function automatic fu_type_e [RS_SZ-1:0] fu_vec_default();
    fu_type_e [RS_SZ-1:0] v;
    for (int i = 0; i < RS_SZ; i++) v[i] = FU_ALU;
    return v;
  endfunction

  rr_class_picker u_picker (
    .ready         (ready),
    .fu_type       (fu_vec),
    .rr_ptr        (rr_ptr_q),
    .lsq_ready     (io.lsq_ready),
    .claims_at_1   (wb_claims_q[1]),
    .claims_at_lat (wb_claims_q[MULT_LAT]),
    .pick          (pick),
    .pick_idx      (pick_idx),
    .pick_vld      (pick_vld),
    .last_idx      (last_idx),
    .new_at_lat    (new_at_lat)
  );

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|pick) rr_ptr_d = last_idx + IDX_W'(1);

    // Offsets are relative to the pick's issue-register cycle, so this cycle's
    // claims land one slot lower after the shift; offset-1 claims expire at once.
    wb_claims_d = '0;
    for (int k = 1; k < MULT_LAT; k++) wb_claims_d[k] = wb_claims_q[k+1];
    wb_claims_d[MULT_LAT-1] = wb_claims_q[MULT_LAT] + new_at_lat;

    iss_valid_d   = '0;
    iss_packets_d = '0;
    for (int j = 0; j < N; j++) begin
      iss_valid_d[j] = pick_vld[j];
      if (pick_vld[j]) iss_packets_d[j] = to_issue(io.rs_data[pick_idx[j]], io.b_mm_resolve);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      wb_claims_q   <= '0;
      iss_packets_q <= '0;
      iss_valid_q   <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wb_claims_q   <= wb_claims_d;
      iss_packets_q <= iss_packets_d;
      iss_valid_q   <= iss_valid_d;
    end
  end

  assign io.rs_data_issuing = pick;
  assign io.iss_packets     = iss_packets_q;
  assign io.iss_valid       = iss_valid_q;

endmodule
